// File: rtl/zicsr_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR addresses, Zicsr funct3 encodings, mstatus bit positions, FSM states.
package zicsr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_BASE     = 16;

  typedef enum logic {ST_RUN = 1'b0, ST_ENTER = 1'b1} trap_state_e;

  // funct3[2] selects the immediate operand; funct3[1:0] selects write/set/clear.
  function automatic logic [31:0] csr_wval(input logic [2:0]  f3,
                                           input logic [31:0] old,
                                           input logic [31:0] rs1,
                                           input logic [4:0]  uimm);
    logic [31:0] opnd;
    opnd = f3[2] ? {27'b0, uimm} : rs1;
    case (f3[1:0])
      2'b01:   csr_wval = opnd;
      2'b10:   csr_wval = old | opnd;
      default: csr_wval = old & ~opnd;
    endcase
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for the external interrupt lines plus a
// lowest-index-wins priority encoder over the enabled, synchronised lines.
module irq_sync #(
  parameter int NUM_IRQ  = 4,
  parameter int IRQ_SYNC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_en,
  output logic [NUM_IRQ-1:0] o_sync,
  output logic               o_any,
  output logic [3:0]         o_idx
);

  logic [IRQ_SYNC-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0]               w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_irq;
      for (int k = 1; k < IRQ_SYNC; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign o_sync = r_sync[IRQ_SYNC-1];
  assign w_hit  = o_sync & i_en;
  assign o_any  = |w_hit;

  // Scan downward so the lowest pending index is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_hit[i]) o_idx = 4'(i);
    end
  end

endmodule

// File: rtl/zicsr_trap_unit.sv
// Machine-mode CSR file with Zicsr ops, 64-bit counters and a two-state
// interrupt entry sequencer that supplies trap and mret redirect PCs.
module zicsr_trap_unit
  import zicsr_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter int          IRQ_SYNC     = 2,
  parameter bit          HAS_COUNTERS = 1'b1,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_en,
  input  logic [11:0]        csr_index,
  input  logic [2:0]         csr_funct3,
  input  logic [31:0]        csr_rs1,
  input  logic [4:0]         csr_uimm,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               boundary,
  input  logic [31:0]        pc_in,
  input  logic               instr_ret,
  input  logic               mret,
  output logic               trap_take,
  output logic [31:0]        trap_pc,
  output logic [31:0]        mret_pc,
  output logic               irq_pending
);

  localparam logic [31:0] MIE_MASK = 32'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);

  trap_state_e        r_state, w_state_nxt;
  logic               r_mstatus_mie, r_mstatus_mpie;
  logic [31:0]        r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [31:0]        w_mstatus, w_mip, w_rdata, w_wdata;
  logic [63:0]        w_mcycle, w_minstret;
  logic [NUM_IRQ-1:0] w_sync;
  logic               w_any, w_pend, w_mapped, w_we, w_take, w_do_mret;
  logic [3:0]         w_idx;

  irq_sync #(.NUM_IRQ(NUM_IRQ), .IRQ_SYNC(IRQ_SYNC)) u_irq_sync (
    .clk    (clk),
    .reset  (reset),
    .i_irq  (irq_in),
    .i_en   (r_mie[IRQ_BASE +: NUM_IRQ]),
    .o_sync (w_sync),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_mip = '0;
    w_mip[IRQ_BASE +: NUM_IRQ] = w_sync;
  end

  always_comb begin
    w_mstatus = '0;
    w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
  end

  assign w_pend      = r_mstatus_mie & w_any;
  assign irq_pending = w_pend;
  assign w_do_mret   = (r_state == ST_RUN) & mret;
  assign w_take      = (r_state == ST_RUN) & w_pend & boundary & ~mret;

  // Read mux is driven by the index alone so rdata is the pre-write value.
  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    case (csr_index)
      CSR_MSTATUS:   w_rdata = w_mstatus;
      CSR_MIE:       w_rdata = r_mie;
      CSR_MTVEC:     w_rdata = r_mtvec;
      CSR_MSCRATCH:  w_rdata = r_mscratch;
      CSR_MEPC:      w_rdata = r_mepc;
      CSR_MCAUSE:    w_rdata = r_mcause;
      CSR_MIP:       w_rdata = w_mip;
      CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH: w_rdata = w_minstret[63:32];
      default:       w_mapped = 1'b0;
    endcase
  end

  assign csr_rdata   = w_rdata;
  assign csr_illegal = csr_en & (~w_mapped | (csr_funct3[1:0] == 2'b00));
  assign w_we        = csr_en & ~csr_illegal;
  assign w_wdata     = csr_wval(csr_funct3, w_rdata, csr_rs1, csr_uimm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_take) w_state_nxt = ST_ENTER;
      ST_ENTER: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    trap_take = (r_state == ST_ENTER);
  end

  // Trap entry, then mret, then the CSR write: at most one touches mstatus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (w_take) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_do_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_we && csr_index == CSR_MSTATUS) begin
      r_mstatus_mie  <= w_wdata[MSTATUS_MIE];
      r_mstatus_mpie <= w_wdata[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (w_take) begin
      r_mepc   <= pc_in & ~32'h3;
      r_mcause <= {1'b1, 31'(IRQ_BASE + int'(w_idx))};
    end else if (w_we) begin
      if (csr_index == CSR_MEPC)   r_mepc   <= w_wdata & ~32'h3;
      if (csr_index == CSR_MCAUSE) r_mcause <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RESET & ~32'h3;
      r_mscratch <= '0;
    end else if (w_we) begin
      if (csr_index == CSR_MIE)      r_mie      <= w_wdata & MIE_MASK;
      if (csr_index == CSR_MTVEC)    r_mtvec    <= w_wdata & ~32'h3;
      if (csr_index == CSR_MSCRATCH) r_mscratch <= w_wdata;
    end
  end

  assign trap_pc = {r_mtvec[31:2], 2'b00};
  assign mret_pc = r_mepc;

  // A half-write replaces that half and suppresses the increment for one cycle.
  if (HAS_COUNTERS) begin : g_cnt
    logic [63:0] r_mcycle, r_minstret;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_mcycle   <= '0;
        r_minstret <= '0;
      end else begin
        if (w_we && csr_index == CSR_MCYCLE)       r_mcycle[31:0]  <= w_wdata;
        else if (w_we && csr_index == CSR_MCYCLEH) r_mcycle[63:32] <= w_wdata;
        else                                       r_mcycle        <= r_mcycle + 64'd1;

        if (w_we && csr_index == CSR_MINSTRET)       r_minstret[31:0]  <= w_wdata;
        else if (w_we && csr_index == CSR_MINSTRETH) r_minstret[63:32] <= w_wdata;
        else if (instr_ret)                          r_minstret        <= r_minstret + 64'd1;
      end
    end

    assign w_mcycle   = r_mcycle;
    assign w_minstret = r_minstret;
  end else begin : g_nocnt
    assign w_mcycle   = '0;
    assign w_minstret = '0;
  end

endmodule
